// File: rtl/out_reg_fifo.sv
// Output buffer for accumulator results: conditions each pushed word (optional
// ReLU, then signed saturation to REG_DATA_WIDTH) and queues it in a DEPTH-entry
// circular FIFO drained over a valid/ready handshake.
//
// Ports:
//   OUT_FIFO_Clk          clock, rising edge
//   OUT_FIFO_Reset        synchronous active-high reset
//   OUT_FIFO_Set          push request
//   OUT_FIFO_Relu_En      clamp negative input to 0 on this push
//   OUT_FIFO_Input_Data   signed IN_DATA_WIDTH result to push
//   OUT_FIFO_Ready        reader accepts head word this cycle
//   OUT_FIFO_Output_Data  signed head word, 0 when not valid
//   OUT_FIFO_Valid        FIFO not empty
//   OUT_FIFO_Full         FIFO holds DEPTH words
//   OUT_FIFO_Count        current occupancy
//   OUT_FIFO_Overflow     sticky flag: a push was dropped
module out_reg_fifo #(
  parameter int unsigned IN_DATA_WIDTH  = 32,
  parameter int unsigned REG_DATA_WIDTH = 16,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned CNT_WIDTH      = $clog2(DEPTH + 1)
) (
  input  logic                             OUT_FIFO_Clk,
  input  logic                             OUT_FIFO_Reset,
  input  logic                             OUT_FIFO_Set,
  input  logic                             OUT_FIFO_Relu_En,
  input  logic signed [IN_DATA_WIDTH-1:0]  OUT_FIFO_Input_Data,
  input  logic                             OUT_FIFO_Ready,
  output logic signed [REG_DATA_WIDTH-1:0] OUT_FIFO_Output_Data,
  output logic                             OUT_FIFO_Valid,
  output logic                             OUT_FIFO_Full,
  output logic [CNT_WIDTH-1:0]             OUT_FIFO_Count,
  output logic                             OUT_FIFO_Overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW    = IN_DATA_WIDTH;
  localparam int unsigned RW    = REG_DATA_WIDTH;

  // Saturation bounds expressed at input width.
  localparam logic signed [IW-1:0] SAT_MAX = {{(IW-RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [IW-1:0] SAT_MIN = {{(IW-RW+1){1'b1}}, {(RW-1){1'b0}}};

  logic [RW-1:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic                 valid_c;
  logic                 full_c;
  logic                 pop_c;
  logic                 push_c;
  logic [RW-1:0]        cond_data_c;

  assign valid_c = (count_q != '0);
  assign full_c  = (count_q == CNT_WIDTH'(DEPTH));
  assign pop_c   = valid_c & OUT_FIFO_Ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_c  = OUT_FIFO_Set & (~full_c | pop_c);

  // Input conditioning: ReLU first, then saturate to the stored width.
  always_comb begin
    cond_data_c = OUT_FIFO_Input_Data[RW-1:0];
    if (OUT_FIFO_Relu_En && OUT_FIFO_Input_Data < 0) begin
      cond_data_c = '0;
    end else if (OUT_FIFO_Input_Data > SAT_MAX) begin
      cond_data_c = SAT_MAX[RW-1:0];
    end else if (OUT_FIFO_Input_Data < SAT_MIN) begin
      cond_data_c = SAT_MIN[RW-1:0];
    end
  end

  // Pointer, occupancy and overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    if (OUT_FIFO_Set && full_c && !pop_c) ovf_d = 1'b1;
  end

  // Control state register.
  always_ff @(posedge OUT_FIFO_Clk) begin
    if (OUT_FIFO_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage; contents are don't-care after reset since count gates the output.
  always_ff @(posedge OUT_FIFO_Clk) begin
    if (!OUT_FIFO_Reset && push_c) begin
      mem_q[wr_ptr_q] <= cond_data_c;
    end
  end

  assign OUT_FIFO_Output_Data = valid_c ? mem_q[rd_ptr_q] : '0;
  assign OUT_FIFO_Valid       = valid_c;
  assign OUT_FIFO_Full        = full_c;
  assign OUT_FIFO_Count       = count_q;
  assign OUT_FIFO_Overflow    = ovf_q;

endmodule

// File: tb/tb_out_reg_fifo.sv
// Self-checking bench for out_reg_fifo: directed scenarios plus a random phase,
// every cycle compared against a queue-based reference model.
module tb_out_reg_fifo;

  localparam int unsigned IW    = 32;
  localparam int unsigned RW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic                 clk;
  logic                 rst;
  logic                 set;
  logic                 relu;
  logic signed [IW-1:0] din;
  logic                 rdy;
  logic signed [RW-1:0] dout;
  logic                 valid;
  logic                 full;
  logic [CW-1:0]        count;
  logic                 ovf;

  int total = 0;
  int bad   = 0;

  longint model_q[$];
  bit     model_ovf;

  out_reg_fifo #(
    .IN_DATA_WIDTH (IW),
    .REG_DATA_WIDTH(RW),
    .DEPTH         (DEPTH),
    .CNT_WIDTH     (CW)
  ) dut (
    .OUT_FIFO_Clk        (clk),
    .OUT_FIFO_Reset      (rst),
    .OUT_FIFO_Set        (set),
    .OUT_FIFO_Relu_En    (relu),
    .OUT_FIFO_Input_Data (din),
    .OUT_FIFO_Ready      (rdy),
    .OUT_FIFO_Output_Data(dout),
    .OUT_FIFO_Valid      (valid),
    .OUT_FIFO_Full       (full),
    .OUT_FIFO_Count      (count),
    .OUT_FIFO_Overflow   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint cond(input bit r, input longint d);
    if (r && d < 0) return 0;
    if (d > 32767) return 32767;
    if (d < -32768) return -32768;
    return d;
  endfunction

  // Compare all outputs against the model (called between edges).
  task automatic check_outputs();
    chk("count", longint'(count), longint'(model_q.size()));
    chk("valid", longint'(valid), (model_q.size() != 0) ? 1 : 0);
    chk("full", longint'(full), (model_q.size() == DEPTH) ? 1 : 0);
    chk("ovf", longint'(ovf), longint'(model_ovf));
    chk("data", longint'(dout), (model_q.size() != 0) ? model_q[0] : 0);
  endtask

  // One clock: check current state, drive inputs, advance DUT and model.
  task automatic cycle(input bit s, input bit r, input longint d, input bit rd, input bit rs);
    bit m_pop, m_full, m_push;
    check_outputs();
    set  = s;
    relu = r;
    din  = IW'(d);
    rdy  = rd;
    rst  = rs;
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      m_pop  = (model_q.size() != 0) && rd;
      m_full = (model_q.size() == DEPTH);
      m_push = s && (!m_full || m_pop);
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(cond(r, d));
      if (s && m_full && !m_pop) model_ovf = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    int sent;
    int recv;
    int budget;
    longint expv;
    bit r;

    set = 0; relu = 0; din = '0; rdy = 0; rst = 1;
    model_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;

    // 1. Reset mid-stream
    cycle(1, 0, 11, 0, 0);
    cycle(1, 0, 22, 0, 0);
    cycle(1, 0, 33, 0, 0);
    chk("pre_rst_count", longint'(count), 3);
    cycle(1, 0, 44, 1, 1);
    chk("rst_count", longint'(count), 0);
    chk("rst_valid", longint'(valid), 0);
    chk("rst_data", longint'(dout), 0);
    chk("rst_ovf", longint'(ovf), 0);

    // 2. Saturation and ReLU
    cycle(1, 0, 40000, 0, 0);
    cycle(1, 0, -40000, 0, 0);
    cycle(1, 1, -5, 0, 0);
    cycle(1, 0, -5, 0, 0);
    cycle(1, 0, 1234, 0, 0);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: expv = 32767;
        1: expv = -32768;
        2: expv = 0;
        3: expv = -5;
        default: expv = 1234;
      endcase
      chk("sat_relu", longint'(dout), expv);
      cycle(0, 0, 0, 1, 0);
    end
    chk("sat_empty", longint'(valid), 0);

    // 3. Fill, full, overflow, drain
    for (int i = 1; i <= 9; i++) begin
      cycle(1, 0, i, 0, 0);
      if (i == 8) chk("fill_full", longint'(full), 1);
    end
    chk("fill_ovf", longint'(ovf), 1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", longint'(dout), i);
      cycle(0, 0, 0, 1, 0);
    end
    chk("drain_ovf_sticky", longint'(ovf), 1);
    cycle(0, 0, 0, 1, 0);

    // 4. Simultaneous push/pop when full
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1, 0, i, 0, 0);
    cycle(1, 0, 9, 1, 0);
    chk("pp_count", longint'(count), 8);
    chk("pp_ovf", longint'(ovf), 0);
    for (int i = 2; i <= 9; i++) begin
      chk("pp_drain", longint'(dout), i);
      cycle(0, 0, 0, 1, 0);
    end

    // 5. Wrap-around with back-pressure
    do_reset();
    sent = 0;
    recv = 0;
    budget = 0;
    while (recv < 20 && budget < 200) begin
      r = ((budget % 4) == 0) || ((budget % 4) == 3);
      if (valid && r) begin
        chk("stream_order", longint'(dout), 100 + recv);
        recv++;
      end
      if (sent < 20 && (model_q.size() < DEPTH || (r && model_q.size() != 0))) begin
        cycle(1, 0, 100 + sent, r, 0);
        sent++;
      end else begin
        cycle(0, 0, 0, r, 0);
      end
      budget++;
    end
    chk("stream_received", recv, 20);
    chk("stream_ovf", longint'(ovf), 0);

    // 6. Empty latency; Ready on empty is ignored
    do_reset();
    cycle(0, 0, 0, 1, 0);
    chk("lat_pre_valid", longint'(valid), 0);
    cycle(1, 0, 77, 1, 0);
    chk("lat_valid", longint'(valid), 1);
    chk("lat_data", longint'(dout), 77);
    cycle(0, 0, 0, 1, 0);

    // Random phase
    do_reset();
    for (int i = 0; i < 600; i++) begin
      longint d;
      case ($urandom_range(0, 3))
        0: d = longint'($signed($urandom()));
        1: d = longint'($urandom_range(0, 70000)) - 35000;
        2: d = longint'($urandom_range(0, 200)) - 100;
        default: d = longint'($urandom_range(0, 65535)) - 32768;
      endcase
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, d,
            $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
